// File: rtl/axi_sram_slave.sv
// AXI4 slave fronting a word-organised on-chip SRAM: one INCR/FIXED burst at a time,
// with byte strobes, range/size checking and per-side grant alternation.
module axi_sram_slave #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_WORDS      = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      aw_valid,
  output logic                      aw_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] aw_addr,
  input  logic [AXI_ID_WIDTH-1:0]   aw_id,
  input  logic [7:0]                aw_len,
  input  logic [2:0]                aw_size,
  input  logic [1:0]                aw_burst,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic [AXI_DATA_WIDTH-1:0] w_data,
  input  logic [3:0]                w_strb,
  input  logic                      w_last,
  output logic                      b_valid,
  input  logic                      b_ready,
  output logic [AXI_ID_WIDTH-1:0]   b_id,
  output logic [1:0]                b_resp,
  input  logic                      ar_valid,
  output logic                      ar_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] ar_addr,
  input  logic [AXI_ID_WIDTH-1:0]   ar_id,
  input  logic [7:0]                ar_len,
  input  logic [2:0]                ar_size,
  input  logic [1:0]                ar_burst,
  output logic                      r_valid,
  input  logic                      r_ready,
  output logic [AXI_DATA_WIDTH-1:0] r_data,
  output logic [AXI_ID_WIDTH-1:0]   r_id,
  output logic [1:0]                r_resp,
  output logic                      r_last
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [AXI_ADDR_WIDTH-3:0] MEM_LIMIT = (AXI_ADDR_WIDTH-2)'(MEM_WORDS);

  typedef enum logic [2:0] {IDLE, WDATA, WRESP, RFETCH, RDATA} state_t;

  state_t                    state, state_nxt;
  logic                      prio_rd, err;
  logic [7:0]                beat, len;
  logic [AXI_ADDR_WIDTH-1:0] addr, addr_nxt;
  logic [AXI_ID_WIDTH-1:0]   id;
  logic [1:0]                burst;
  logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [AXI_DATA_WIDTH-1:0] rdata;
  logic [IDX_W-1:0]          idx;
  logic                      addr_oor, last_beat, r_bad;
  logic                      aw_hs, ar_hs, w_hs, r_hs, aw_err, ar_err;

  assign idx       = addr[IDX_W+1:2];
  assign addr_oor  = (addr[AXI_ADDR_WIDTH-1:2] >= MEM_LIMIT);
  assign last_beat = (beat == len);
  assign addr_nxt  = (burst == 2'b01) ? addr + AXI_ADDR_WIDTH'(4) : addr;
  assign aw_err    = (aw_size != 3'd2) || aw_burst[1];
  assign ar_err    = (ar_size != 3'd2) || ar_burst[1];
  assign aw_hs     = aw_valid && aw_ready;
  assign ar_hs     = ar_valid && ar_ready;
  assign w_hs      = w_valid && w_ready;
  assign r_hs      = r_valid && r_ready;

  // Read error combines the burst-wide size/type flag with this beat's range check.
  assign r_bad  = err || addr_oor;
  assign r_data = (r_valid && !r_bad) ? rdata : '0;
  assign r_resp = (r_valid && r_bad) ? 2'b10 : 2'b00;
  assign r_last = r_valid && last_beat;
  assign r_id   = r_valid ? id : '0;
  assign b_id   = b_valid ? id : '0;
  assign b_resp = (b_valid && err) ? 2'b10 : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    aw_ready  = 1'b0;
    ar_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    r_valid   = 1'b0;
    case (state)
      IDLE: begin
        aw_ready = aw_valid && !(ar_valid && prio_rd);
        ar_ready = ar_valid && !(aw_valid && !prio_rd);
        if (aw_ready)      state_nxt = WDATA;
        else if (ar_ready) state_nxt = RFETCH;
      end
      WDATA: begin
        w_ready = 1'b1;
        if (w_valid && last_beat) state_nxt = WRESP;
      end
      WRESP: begin
        b_valid = 1'b1;
        if (b_ready) state_nxt = IDLE;
      end
      RFETCH: state_nxt = RDATA;
      RDATA: begin
        r_valid = 1'b1;
        if (r_ready) state_nxt = last_beat ? IDLE : RFETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Winning side hands priority to the other side for the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_rd <= 1'b1;
      err     <= 1'b0;
      beat    <= 8'd0;
    end else if (aw_hs) begin
      prio_rd <= 1'b1;
      err     <= aw_err;
      beat    <= 8'd0;
    end else if (ar_hs) begin
      prio_rd <= 1'b0;
      err     <= ar_err;
      beat    <= 8'd0;
    end else if (w_hs) begin
      err  <= err || addr_oor || (w_last != last_beat);
      beat <= beat + 8'd1;
    end else if (r_hs && !last_beat) begin
      beat <= beat + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) begin
      addr  <= aw_addr;
      id    <= aw_id;
      len   <= aw_len;
      burst <= aw_burst;
    end else if (ar_hs) begin
      addr  <= ar_addr;
      id    <= ar_id;
      len   <= ar_len;
      burst <= ar_burst;
    end else if (w_hs || (r_hs && !last_beat)) begin
      addr <= addr_nxt;
    end
    if (state == RFETCH) rdata <= mem[idx];
  end

  always_ff @(posedge clk) begin
    if (w_hs && !err && !addr_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) mem[idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed and randomized bench for axi_sram_slave against a word-array memory model.
module tb_axi_sram_slave;

  localparam int MEM_WORDS = 1024;
  localparam int IW = $clog2(MEM_WORDS);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [31:0] aw_addr, ar_addr, w_data, r_data;
  logic [3:0]  aw_id, ar_id, b_id, r_id, w_strb;
  logic [7:0]  aw_len, ar_len;
  logic [2:0]  aw_size, ar_size;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;

  logic [31:0] mdl [MEM_WORDS];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic        wl [256];
  logic        favour_read;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  axi_sram_slave #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(4),
                   .MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_id(r_id),
    .r_resp(r_resp), .r_last(r_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Burst payload: full strobes, w_last only on the final beat, data from base+i.
  task automatic fill(input logic [7:0] len, input logic [31:0] base);
    for (int i = 0; i < 256; i++) begin
      wd[i] = base + 32'(i);
      ws[i] = 4'hF;
      wl[i] = (i == int'(len));
    end
  endtask

  task automatic drive_aw(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id);
    aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_id = id; aw_valid = 1'b1;
  endtask

  task automatic drive_ar(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id);
    ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_id = id; ar_valid = 1'b1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id);
    logic        bad;
    logic [31:0] a, word;
    int          n;
    bad = (size != 3'd2) || (burst != 2'b00 && burst != 2'b01);
    for (int i = 0; i <= int'(len); i++) begin
      a    = (burst == 2'b01) ? addr + 32'(4 * i) : addr;
      word = a >> 2;
      if (!bad && word < MEM_WORDS)
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) mdl[word[IW-1:0]][8*b +: 8] = wd[i][8*b +: 8];
      if (word >= MEM_WORDS || wl[i] != (i == int'(len))) bad = 1'b1;
    end
    drive_aw(addr, len, size, burst, id);
    #1;
    n = 0;
    while (!aw_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("aw_ready", {31'd0, aw_ready}, 32'd1);
    @(posedge clk); #1;
    aw_valid = 1'b0;
    favour_read = 1'b1;
    check("w_ready_after_aw", {31'd0, w_ready}, 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      w_valid = 1'b1; w_data = wd[i]; w_strb = ws[i]; w_last = wl[i];
      @(posedge clk); #1;
    end
    w_valid = 1'b0; w_last = 1'b0;
    check("b_valid", {31'd0, b_valid}, 32'd1);
    check("b_id", {28'd0, b_id}, {28'd0, id});
    check("b_resp", {30'd0, b_resp}, bad ? 32'd2 : 32'd0);
    b_ready = 1'b1;
    @(posedge clk); #1;
    b_ready = 1'b0;
    check("b_valid_drop", {31'd0, b_valid}, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id, input int hold);
    logic        bad_b, bad;
    logic [31:0] a, word, ed;
    int          n;
    bad_b = (size != 3'd2) || (burst != 2'b00 && burst != 2'b01);
    drive_ar(addr, len, size, burst, id);
    #1;
    n = 0;
    while (!ar_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("ar_ready", {31'd0, ar_ready}, 32'd1);
    @(posedge clk); #1;
    ar_valid = 1'b0;
    favour_read = 1'b0;
    check("r_valid_T+1", {31'd0, r_valid}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i <= int'(len); i++) begin
      a    = (burst == 2'b01) ? addr + 32'(4 * i) : addr;
      word = a >> 2;
      bad  = bad_b || (word >= MEM_WORDS);
      ed   = bad ? 32'd0 : mdl[word[IW-1:0]];
      check("r_valid", {31'd0, r_valid}, 32'd1);
      check("r_data", r_data, ed);
      check("r_resp", {30'd0, r_resp}, bad ? 32'd2 : 32'd0);
      check("r_last", {31'd0, r_last}, (i == int'(len)) ? 32'd1 : 32'd0);
      check("r_id", {28'd0, r_id}, {28'd0, id});
      if (i == 0)
        for (int h = 0; h < hold; h++) begin
          @(posedge clk); #1;
          check("hold_r_valid", {31'd0, r_valid}, 32'd1);
          check("hold_r_data", r_data, ed);
          check("hold_r_last", {31'd0, r_last}, (len == 8'd0) ? 32'd1 : 32'd0);
          check("hold_r_id", {28'd0, r_id}, {28'd0, id});
        end
      r_ready = 1'b1;
      @(posedge clk); #1;
      r_ready = 1'b0;
      if (i != int'(len)) begin
        check("r_bubble", {31'd0, r_valid}, 32'd0);
        @(posedge clk); #1;
      end
    end
    check("r_valid_end", {31'd0, r_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [7:0]  rl;
    logic [1:0]  rb;
    int          n;
    rst_n = 1'b0; favour_read = 1'b1;
    aw_valid = 0; aw_addr = 0; aw_id = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
    ar_valid = 0; ar_addr = 0; ar_id = 0; ar_len = 0; ar_size = 0; ar_burst = 0; r_ready = 0;
    #1;
    check("rst_outputs", {aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last, b_resp, r_resp},
          32'd0);
    check("rst_ids_data", r_data | {24'd0, b_id, r_id}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Simultaneous AW+AR: read served first, then with AR re-raised the write wins.
    fill(8'd3, 32'hA0);
    drive_aw(32'h100, 8'd3, 3'd2, 2'b01, 4'd3);
    drive_ar(32'h40, 8'd0, 3'd1, 2'b01, 4'd5);
    #1;
    check("pair1_ar_ready", {31'd0, ar_ready}, {31'd0, favour_read});
    check("pair1_aw_ready", {31'd0, aw_ready}, {31'd0, !favour_read});
    do_read(32'h40, 8'd0, 3'd1, 2'b01, 4'd5, 0);
    drive_ar(32'h100, 8'd3, 3'd2, 2'b01, 4'd9);
    #1;
    check("pair2_aw_ready", {31'd0, aw_ready}, {31'd0, !favour_read});
    check("pair2_ar_ready", {31'd0, ar_ready}, {31'd0, favour_read});
    do_write(32'h100, 8'd3, 3'd2, 2'b01, 4'd3);
    do_read(32'h100, 8'd3, 3'd2, 2'b01, 4'd9, 5);

    // Byte strobes merge into an all-ones word.
    fill(8'd0, 32'hFFFF_FFFF);
    do_write(32'h200, 8'd0, 3'd2, 2'b01, 4'd1);
    wd[0] = 32'h1122_3344; ws[0] = 4'b0101;
    do_write(32'h200, 8'd0, 3'd2, 2'b01, 4'd2);
    do_read(32'h200, 8'd0, 3'd2, 2'b01, 4'd2, 0);

    // Burst crossing the top of memory.
    fill(8'd1, 32'h5500);
    do_write(32'((MEM_WORDS - 1) * 4), 8'd1, 3'd2, 2'b01, 4'd6);
    do_read(32'((MEM_WORDS - 1) * 4), 8'd1, 3'd2, 2'b01, 4'd6, 0);

    // Illegal size / burst type leave memory untouched.
    fill(8'd0, 32'hCAFE_0000);
    do_write(32'h300, 8'd0, 3'd2, 2'b01, 4'd7);
    fill(8'd0, 32'hDEAD_0000);
    do_write(32'h300, 8'd0, 3'd1, 2'b01, 4'd7);
    do_write(32'h300, 8'd0, 3'd2, 2'b10, 4'd8);
    do_read(32'h300, 8'd0, 3'd2, 2'b01, 4'd8, 0);

    // Early w_last on a 3-beat burst.
    fill(8'd2, 32'h7700);
    wl[0] = 1'b1; wl[2] = 1'b0;
    do_write(32'h340, 8'd2, 3'd2, 2'b01, 4'd10);

    // FIXED burst keeps hitting one word.
    fill(8'd2, 32'h8800);
    do_write(32'h380, 8'd2, 3'd2, 2'b00, 4'd11);
    do_read(32'h380, 8'd2, 3'd2, 2'b00, 4'd11, 0);

    // 256-beat burst over words 0..255.
    fill(8'd255, 32'h0);
    for (int i = 0; i < 256; i++) wd[i] = $urandom;
    do_write(32'h0, 8'd255, 3'd2, 2'b01, 4'd12);
    do_read(32'h0, 8'd255, 3'd2, 2'b01, 4'd12, 0);

    // Randomized bursts inside the initialised region.
    for (int k = 0; k < 8; k++) begin
      ra = 32'($urandom_range(0, 200)) << 2;
      rl = 8'($urandom_range(0, 15));
      rb = 2'($urandom_range(0, 1));
      fill(rl, 32'h0);
      for (int i = 0; i <= int'(rl); i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      do_write(ra, rl, 3'd2, rb, 4'(k));
      do_read(ra, rl, 3'd2, rb, 4'(k + 1), 0);
    end

    // Reset asserted in the middle of a write burst.
    fill(8'd3, 32'h3000);
    do_write(32'(300 * 4), 8'd3, 3'd2, 2'b01, 4'd13);
    drive_aw(32'(300 * 4), 8'd3, 3'd2, 2'b01, 4'd14);
    #1;
    n = 0;
    while (!aw_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("rst_aw_ready", {31'd0, aw_ready}, 32'd1);
    @(posedge clk); #1;
    aw_valid = 1'b0;
    w_valid = 1'b1; w_data = 32'h9999_0000; w_strb = 4'hF; w_last = 1'b0;
    @(posedge clk); #1;
    mdl[300] = 32'h9999_0000;
    w_data = 32'h9999_0001;
    #1 rst_n = 1'b0;
    #1;
    check("rst_w_ready_drop", {31'd0, w_ready}, 32'd0);
    check("rst_b_valid", {31'd0, b_valid}, 32'd0);
    w_valid = 1'b0;
    favour_read = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_b_valid_after", {31'd0, b_valid}, 32'd0);
    do_read(32'(300 * 4), 8'd3, 3'd2, 2'b01, 4'd15, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI4 slave responder backing one `slaves[]` port of `axi_node_intf_wrap` with a word-organised on-chip SRAM. It accepts one burst at a time from the interconnect, on either the write or the read channel set. It performs INCR/FIXED bursts with byte strobes and returns B and R responses with the request ID. It is the responder counterpart of the core and debug AXI initiators, used as a generic data/instruction memory or scratch region behind the node.

## Interface
- `AXI_ADDR_WIDTH`, 32, address width
- `AXI_DATA_WIDTH`, 32, data width (fixed 32; 4 strobe bits)
- `AXI_ID_WIDTH`, 4, slave-side ID width (node-extended)
- `MEM_WORDS`, 1024, SRAM depth in 32-bit words (power of two)
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `aw_valid`/`aw_ready`  in/out  1  write-address handshake
- `aw_addr`, `aw_id`, `aw_len`, `aw_size`, `aw_burst`  in  32/ID/8/3/2  write-address fields
- `w_valid`/`w_ready`  in/out  1  write-data handshake
- `w_data`, `w_strb`, `w_last`  in  32/4/1  write data, byte enables, last flag
- `b_valid`/`b_ready`  out/in  1  write-response handshake
- `b_id`, `b_resp`  out  ID/2  response ID, OKAY=00 / SLVERR=10
- `ar_valid`/`ar_ready`  in/out  1  read-address handshake
- `ar_addr`, `ar_id`, `ar_len`, `ar_size`, `ar_burst`  in  32/ID/8/3/2  read-address fields
- `r_valid`/`r_ready`  out/in  1  read-data handshake
- `r_data`, `r_id`, `r_resp`, `r_last`  out  32/ID/2/1  read beat

## Operation
- FSM states: IDLE, WDATA, WRESP, RFETCH, RDATA. Reset → IDLE, `prio_rd`=1.
- IDLE: `aw_ready` = `aw_valid` && !(`ar_valid` && `prio_rd`). `ar_ready` = `ar_valid` && !(`aw_valid` && !`prio_rd`). All other states drive both low.
- Grant: when both valid, the side selected by `prio_rd` wins and `prio_rd` toggles. When a single request is granted, `prio_rd` is set to favour the other side.
- AW accept: latch addr, id, len, burst. `err` = (`aw_size`≠2) or (`aw_burst`∉{FIXED 00, INCR 01}). `beat`=0. Go to WDATA.
- WDATA: `w_ready`=1. Each handshake writes the strobed bytes to word `addr[31:2]`, unless `err` or the word is out of range (`addr[31:2]` ≥ MEM_WORDS). An out-of-range beat sets `err`.
  - INCR adds 4 to addr, modulo 2^32. FIXED holds addr.
  - The burst ends on the beat where `beat`==len, regardless of `w_last`. `w_last` mismatch on any beat (early or missing) sets `err`. Then go to WRESP.
- WRESP: `b_valid`=1, `b_id`=latched id, `b_resp`=`err`?10:00. Stable until `b_ready`, then IDLE.
- AR accept: latch the same fields and the same `err` rule. Go to RFETCH.
- RFETCH: synchronous SRAM read of the current word. Go to RDATA.
- RDATA: `r_valid`=1. `r_data` = word, or 0 if `err` or out of range. `r_resp`=10 in that case, else 00. `r_last` = (`beat`==len), `r_id`=latched id. All R outputs are stable while `r_valid`&&!`r_ready`.
  - On handshake: if last, go to IDLE; else advance addr as for writes, `beat`+1, go to RFETCH.
- Read `err` is per beat for range and per burst for size/burst type.
- SRAM contents are not reset.

## Timing
- Reset values: all `*_ready`, `*_valid`, `r_last` = 0. `b_resp`, `r_resp`, `b_id`, `r_id`, `r_data` = 0.
- Reset assertion mid-burst aborts immediately: outputs reach reset values with no clock edge, and no further SRAM write occurs. Partial writes already performed remain.
- Write: AW handshake at edge T → `w_ready`=1 in cycle T+1. One beat per cycle. Last beat handshake at edge U → `b_valid` in cycle U+1.
- Read: AR handshake at edge T → `r_valid` in cycle T+2. Beat handshake at edge U → next `r_valid` in cycle U+2, so one bubble per beat.
- After B or final R handshake, IDLE is re-entered and a new AW/AR can be accepted on the next edge.
- Back-to-back write-then-read to the same word returns the new data; there is no forwarding hazard because the FSM is serial.
- `aw_len`=255 is a 256-beat burst; the beat counter is 8 bits and must not wrap early.

## Test plan
- Write INCR len=3 at 0x100, data 0xA0..0xA3, strb=F → `b_resp`=00. Read back INCR len=3 returns 0xA0..0xA3 with `r_last` only on beat 3 and `r_valid` first seen 2 cycles after AR.
- Write 0x11223344 with strb=0101 over a word holding 0xFFFFFFFF → readback 0xFF22FF44.
- AW and AR asserted in the same cycle, both held → read served first (reset `prio_rd`=1). The next simultaneous pair serves the write first.
- Write INCR len=1 starting at word MEM_WORDS-1 → beat 0 written, beat 1 suppressed, `b_resp`=10. Read of the same range gives beat 0 OKAY and beat 1 data 0 / SLVERR.
- `aw_size`=1 or `aw_burst`=10 → no SRAM change and `b_resp`=10. `w_last` at beat 0 of a len=2 burst → 3 beats still accepted, `b_resp`=10.
- Hold `r_ready`=0 for 5 cycles in RDATA → `r_data`, `r_last`, `r_id` unchanged. Assert `rst_n`=0 mid-write-burst → `w_ready`/`b_valid` drop with no clock edge, and the FSM is in IDLE after release.
